// File: rtl/ah_cam_pool.sv
// Content-addressable entry pool: it allocates the lowest free slot on a write and answers
// lookups by key with a registered response. A lookup can also free the lowest matching slot.
module ah_cam_pool #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned KEY_W  = 10,
  parameter int unsigned DEPTH  = 10,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic [IDX_W-1:0]  wr_idx,
  input  logic              snoop_valid,
  input  logic [KEY_W-1:0]  snoop_key,
  input  logic              snoop_free,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_multi,
  output logic [IDX_W-1:0]  resp_idx,
  output logic [DATA_W-1:0] resp_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0][DATA_W-1:0] entry_q;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [CNT_W-1:0]             count_q, count_d;

  logic              wr_fire, free_fire;
  logic              hit, multi;
  logic [IDX_W-1:0]  hit_idx;
  logic [DATA_W-1:0] hit_data;

  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = ~full & ~flush;
  assign wr_fire  = wr_valid & wr_ready;

  // Lowest free slot; only meaningful while wr_ready is high.
  always_comb begin
    wr_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) wr_idx = IDX_W'(i);
    end
  end

  // Lookup runs on the registered contents, so a same-cycle write is not visible to it.
  always_comb begin
    hit      = 1'b0;
    multi    = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i][KEY_W-1:0] == snoop_key)) begin
        if (hit) begin
          multi = 1'b1;
        end else begin
          hit      = 1'b1;
          hit_idx  = IDX_W'(i);
          hit_data = entry_q[i];
        end
      end
    end
  end

  assign free_fire = snoop_valid & snoop_free & hit & ~flush;

  // The freed slot is always valid and the write slot invalid, so the two never collide.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_fire && (hit_idx == IDX_W'(i))) valid_d[i] = 1'b0;
      if (wr_fire && (wr_idx == IDX_W'(i)))    valid_d[i] = 1'b1;
    end
    if (flush) valid_d = '0;
  end

  always_comb begin
    count_d = count_q + CNT_W'(wr_fire) - CNT_W'(free_fire);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q    <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_multi <= 1'b0;
      resp_idx   <= '0;
      resp_data  <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_fire && (wr_idx == IDX_W'(i))) entry_q[i] <= wr_data;
      end
      resp_valid <= snoop_valid;
      if (snoop_valid) begin
        resp_hit   <= hit;
        resp_multi <= multi;
        resp_idx   <= hit_idx;
        resp_data  <= hit_data;
      end
    end
  end

endmodule
